// File: rtl/ps2_led_cmd.sv
// PS/2 host LED command sequencer: sends 0xED then the LED mask, waits for a device
// ACK after each byte, retries on RESEND or ACK timeout, and coalesces requests made while busy.
module ps2_led_cmd #(
  parameter int unsigned ACK_TIMEOUT = 24000,
  parameter int unsigned TMO_W       = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] leds,
  input  logic       led_update,
  input  logic       tx_busy,
  output logic       tx_wren,
  output logic [7:0] tx_d,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       error
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(ACK_TIMEOUT);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_TXWAIT, ST_TXRUN, ST_ACKWAIT, ST_RETRY
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         cur, cur_nxt;
  logic               arg_phase, arg_phase_nxt;
  logic               resend_path, resend_path_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [TMO_W-1:0]   timer, timer_nxt, timer_inc;
  logic               pending, pending_nxt;
  logic [2:0]         mask, mask_nxt;
  logic               tx_wren_nxt, busy_nxt, error_nxt;
  logic [7:0]         tx_d_nxt;

  // State, context and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      arg_phase   <= 1'b0;
      resend_path <= 1'b0;
      retry       <= '0;
      timer       <= '0;
      pending     <= 1'b0;
      mask        <= '0;
      tx_wren     <= 1'b0;
      tx_d        <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      arg_phase   <= arg_phase_nxt;
      resend_path <= resend_path_nxt;
      retry       <= retry_nxt;
      timer       <= timer_nxt;
      pending     <= pending_nxt;
      mask        <= mask_nxt;
      tx_wren     <= tx_wren_nxt;
      tx_d        <= tx_d_nxt;
      busy        <= busy_nxt;
      error       <= error_nxt;
    end
  end

  // Saturating increment; a timeout fires on the cycle the count reaches the limit
  assign timer_inc = (timer == TMO_LIMIT) ? timer : timer + TMO_W'(1);

  always_comb begin
    state_nxt       = state;
    cur_nxt         = cur;
    arg_phase_nxt   = arg_phase;
    resend_path_nxt = resend_path;
    retry_nxt       = retry;
    timer_nxt       = timer;
    pending_nxt     = pending;
    mask_nxt        = led_update ? leds : mask;
    error_nxt       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pending && !tx_busy) begin
          state_nxt     = ST_SEND;
          cur_nxt       = CMD_SET_LEDS;
          arg_phase_nxt = 1'b0;
          retry_nxt     = '0;
          pending_nxt   = 1'b0;
        end
      end
      ST_SEND: begin
        timer_nxt = '0;
        state_nxt = ST_TXWAIT;
      end
      ST_TXWAIT: state_nxt = ST_TXRUN;
      ST_TXRUN: begin
        if (!tx_busy) begin
          state_nxt = ST_ACKWAIT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
          if (timer_inc == TMO_LIMIT) begin
            state_nxt       = ST_RETRY;
            resend_path_nxt = 1'b0;
          end
        end
      end
      ST_ACKWAIT: begin
        timer_nxt = timer_inc;
        // A received byte takes priority over a same-cycle timeout
        if (rx_valid && rx_data == RSP_ACK) begin
          if (!arg_phase) begin
            cur_nxt       = {5'b0, mask};
            arg_phase_nxt = 1'b1;
            state_nxt     = ST_SEND;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (rx_valid && rx_data == RSP_RESEND) begin
          state_nxt       = ST_RETRY;
          resend_path_nxt = 1'b1;
        end else if (timer_inc == TMO_LIMIT) begin
          state_nxt       = ST_RETRY;
          resend_path_nxt = 1'b0;
        end
      end
      ST_RETRY: begin
        if (retry == RETRY_MAX) begin
          error_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!tx_busy) begin
          retry_nxt = retry + RETRY_W'(1);
          state_nxt = ST_SEND;
          if (!resend_path) begin
            cur_nxt       = CMD_SET_LEDS;
            arg_phase_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Applied last so a request in the launch cycle keeps pending set
    if (led_update) pending_nxt = 1'b1;

    tx_wren_nxt = (state_nxt == ST_SEND);
    tx_d_nxt    = tx_wren_nxt ? cur_nxt : tx_d;
    busy_nxt    = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_ps2_led_cmd.sv
// Bench for ps2_led_cmd: transmitter and keyboard models plus a transaction-level
// model predicting the bytes sent and error pulses for each response script.
module tb_ps2_led_cmd;

  localparam int T    = 40;
  localparam int MAXR = 3;
  localparam int R_ACK = 0, R_RESEND = 1, R_SILENT = 2, R_STRAY = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] leds;
  logic       led_update;
  logic       tx_busy = 1'b0;
  logic       tx_wren;
  logic [7:0] tx_d;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       error;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, gen = 0, tx_len = 4, tx_cnt = 0, fixed_delay = 0;
  int err_cnt = 0, err_cyc = 0, exp_err = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  int send_cyc[$];
  int resp_q[$];
  int script_q[$];

  ps2_led_cmd #(.ACK_TIMEOUT(T), .TMO_W(8), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .leds(leds), .led_update(led_update),
    .tx_busy(tx_busy), .tx_wren(tx_wren), .tx_d(tx_d),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for tx_len cycles starting the cycle after the write strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_wren) begin
      tx_busy <= 1'b1;
      tx_cnt  <= tx_len - 1;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_wren) begin
      sent_q.push_back(tx_d);
      send_cyc.push_back(cyc);
    end
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Keyboard: answers each frame according to the next scripted response
  task automatic dev_frame();
    logic [7:0] sent;
    int kind, d, g, cnt;
    sent = tx_d;
    g    = gen;
    kind = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
    @(negedge clk);
    if (kind == R_STRAY) begin
      @(negedge clk);
      rx_pulse(8'hFA);
    end
    cnt = 0;
    while (tx_busy && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("dev_txdone_bound", 32'(cnt < 2000), 1);
    if (g != gen || kind == R_SILENT) return;
    d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, T / 2));
    repeat (d) @(negedge clk);
    if (g != gen) return;
    case (kind)
      R_RESEND: rx_pulse(8'hFE);
      R_STRAY: begin
        rx_pulse(8'hAA);
        rx_pulse(8'hFA);
      end
      default: rx_pulse(8'hFA);
    endcase
    if (kind != R_RESEND && g == gen) begin
      if (sent == 8'hED) check("ack_to_send", tx_wren, 1);
      else check("ack_to_idle_busy", busy, 0);
    end
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      while (tx_wren === 1'b1) dev_frame();
    end
  end

  function automatic int rand_kind();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60) return R_ACK;
    if (r < 75) return R_RESEND;
    if (r < 85) return R_SILENT;
    return R_STRAY;
  endfunction

  // Reference: walk the protocol one transmitted byte at a time
  task automatic plan(input logic [2:0] m, input bit rnd);
    logic [7:0] cur;
    bit arg_phase, done;
    int retries, k;
    cur = 8'hED; arg_phase = 1'b0; retries = 0; done = 1'b0;
    exp_q.delete(); resp_q.delete(); exp_err = 0;
    while (!done) begin
      exp_q.push_back(cur);
      if (script_q.size() > 0) k = script_q.pop_front();
      else if (rnd) k = rand_kind();
      else k = R_ACK;
      resp_q.push_back(k);
      if (k == R_ACK || k == R_STRAY) begin
        if (arg_phase) done = 1'b1;
        else begin
          arg_phase = 1'b1;
          cur = {5'b0, m};
        end
      end else if (retries == MAXR) begin
        exp_err = 1;
        done = 1'b1;
      end else begin
        retries++;
        if (k == R_SILENT) begin
          cur = 8'hED;
          arg_phase = 1'b0;
        end
      end
    end
  endtask

  task automatic led_req(input logic [2:0] m);
    leds = m;
    led_update = 1'b1;
    @(negedge clk);
    led_update = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet, cnt;
    quiet = 0; cnt = 0;
    while (quiet < 6 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
      if (!busy && !tx_busy && !rx_valid) quiet++;
      else quiet = 0;
    end
    check({tag, " done_bound"}, 32'(cnt < 5000), 1);
  endtask

  task automatic wait_tx_done(input string tag);
    int cnt;
    cnt = 0;
    while (!tx_busy && cnt < 100) begin @(negedge clk); cnt++; end
    while (tx_busy && cnt < 2000) begin @(negedge clk); cnt++; end
    check({tag, " tx_bound"}, 32'(cnt < 2000), 1);
  endtask

  task automatic compare(input string tag);
    check({tag, " n_sent"}, sent_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < sent_q.size()) check($sformatf("%s byte%0d", tag, i), sent_q[i], exp_q[i]);
    check({tag, " err"}, err_cnt, exp_err);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic clear_obs();
    sent_q.delete(); send_cyc.delete(); err_cnt = 0;
  endtask

  task automatic run_seq(input logic [2:0] m, input string tag);
    clear_obs();
    led_req(m);
    wait_idle(tag);
    compare(tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; leds = 3'b000; led_update = 1'b0;
    repeat (3) @(negedge clk);
    check("rst tx_wren", tx_wren, 0);
    check("rst tx_d", tx_d, 8'h00);
    check("rst busy", busy, 0);
    check("rst error", error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Both bytes acknowledged
    tx_len = 4;
    plan(3'b101, 1'b0);
    run_seq(3'b101, "t1");

    // RESEND on the argument byte
    script_q = {R_ACK, R_RESEND, R_ACK};
    plan(3'b101, 1'b0);
    run_seq(3'b101, "t2");

    // No ACK at all: four tries then error
    tx_len = 5;
    script_q = {R_SILENT, R_SILENT, R_SILENT, R_SILENT};
    plan(3'b101, 1'b0);
    run_seq(3'b101, "t3");
    for (int i = 0; i + 1 < send_cyc.size(); i++)
      check($sformatf("t3 retry_gap%0d", i), send_cyc[i+1] - send_cyc[i], tx_len + T + 3);
    if (send_cyc.size() > 0)
      check("t3 err_time", err_cyc - send_cyc[send_cyc.size()-1], tx_len + T + 3);

    // ACK in the final cycle of the wait window still counts
    tx_len = 3; fixed_delay = T;
    plan(3'b110, 1'b0);
    run_seq(3'b110, "t_last");
    fixed_delay = 0;

    // Stray bytes: 0xFA while transmitting, 0xAA while waiting
    tx_len = 4;
    script_q = {R_STRAY, R_ACK};
    plan(3'b101, 1'b0);
    run_seq(3'b101, "t5");

    // Two requests while busy coalesce into one extra sequence
    fixed_delay = 12;
    resp_q.delete();
    exp_q = {8'hED, 8'h01, 8'hED, 8'h02};
    exp_err = 0;
    clear_obs();
    led_req(3'b111);
    while (sent_q.size() < 1 && !busy) @(negedge clk);
    wait_tx_done("t4a");
    repeat (3) @(negedge clk);
    led_req(3'b001);
    while (sent_q.size() < 2 && busy) @(negedge clk);
    wait_tx_done("t4b");
    repeat (3) @(negedge clk);
    led_req(3'b010);
    wait_idle("t4");
    compare("t4");
    fixed_delay = 0;

    // Reset while the command byte is on the wire
    tx_len = 8;
    resp_q.delete();
    clear_obs();
    led_req(3'b011);
    begin
      int cnt;
      cnt = 0;
      while (tx_wren !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
      check("t6 launch_bound", 32'(cnt < 50), 1);
    end
    @(negedge clk);
    @(negedge clk);
    gen++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 tx_wren", tx_wren, 0);
    check("t6 tx_d", tx_d, 8'h00);
    check("t6 busy", busy, 0);
    check("t6 error", error, 0);
    repeat (60) @(negedge clk);
    check("t6 no_relaunch", sent_q.size(), 1);
    check("t6 idle", busy, 0);
    tx_len = 4;
    plan(3'b100, 1'b0);
    run_seq(3'b100, "t6 recover");

    // Randomised scripts, masks, frame lengths and reply delays
    for (int n = 0; n < 15; n++) begin
      logic [2:0] m;
      m = 3'($urandom);
      tx_len = int'($urandom_range(3, 8));
      plan(m, 1'b1);
      run_seq(m, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
